// File: rtl/seq_divider_32bits.sv
// Sequential 32-bit radix-2 non-restoring divider, signed or unsigned operands.
// One quotient bit per cycle over 32 cycles; start/done handshake shared with the Booth multiplier.
module seq_divider_32bits (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        op_done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [32:0] rem_acc_q, rem_acc_d;   // signed partial remainder R
    logic [31:0] quo_acc_q, quo_acc_d;   // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q, dvs_d;           // divisor magnitude D
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;

    // Operand conditioning at the sampling edge
    logic        dvd_neg, dvs_neg;
    logic [31:0] dvd_mag, dvs_mag;

    always_comb begin
        dvd_neg = signed_op & dividend[31];
        dvs_neg = signed_op & divisor[31];
        dvd_mag = dvd_neg ? (32'd0 - dividend) : dividend;
        dvs_mag = dvs_neg ? (32'd0 - divisor) : divisor;
    end

    // One iteration: the sign of R before the shift selects add or subtract.
    // 33-bit wraparound in the shifted term is harmless because the result lies in [-D, D).
    logic [32:0] rem_shift, rem_addend, rem_iter;
    logic [31:0] quo_iter;
    logic        sub_sel;
    logic [31:0] rem_fix, quo_final, rem_final;

    always_comb begin
        sub_sel    = ~rem_acc_q[32];
        rem_shift  = {rem_acc_q[31:0], quo_acc_q[31]};
        rem_addend = sub_sel ? ~{1'b0, dvs_q} : {1'b0, dvs_q};
        rem_iter   = rem_shift + rem_addend + {32'd0, sub_sel};
        quo_iter   = {quo_acc_q[30:0], ~rem_iter[32]};
        rem_fix    = rem_iter[32] ? (rem_iter[31:0] + dvs_q) : rem_iter[31:0];
        quo_final  = neg_quo_q ? (32'd0 - quo_iter) : quo_iter;
        rem_final  = neg_rem_q ? (32'd0 - rem_fix) : rem_fix;
    end

    always_comb begin
        state_d     = state_q;
        rem_acc_d   = rem_acc_q;
        quo_acc_d   = quo_acc_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        if (op_clear) begin
            state_d     = StIdle;
            quotient_d  = 32'd0;
            remainder_d = 32'd0;
            div_zero_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (op_start) begin
                        if (divisor == 32'd0) begin
                            state_d     = StDone;
                            quotient_d  = 32'hFFFF_FFFF;
                            remainder_d = dividend;
                            div_zero_d  = 1'b1;
                        end else begin
                            state_d    = StExec;
                            rem_acc_d  = 33'd0;
                            quo_acc_d  = dvd_mag;
                            dvs_d      = dvs_mag;
                            cnt_d      = 6'd0;
                            neg_quo_d  = dvd_neg ^ dvs_neg;
                            neg_rem_d  = dvd_neg;
                            div_zero_d = 1'b0;
                        end
                    end
                end
                StExec: begin
                    rem_acc_d = rem_iter;
                    quo_acc_d = quo_iter;
                    cnt_d     = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d     = StDone;
                        quotient_d  = quo_final;
                        remainder_d = rem_final;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rem_acc_q   <= 33'd0;
            quo_acc_q   <= 32'd0;
            dvs_q       <= 32'd0;
            cnt_q       <= 6'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_acc_q   <= rem_acc_d;
            quo_acc_q   <= quo_acc_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = (state_q == StExec);
    assign op_done   = (state_q == StDone);
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider_32bits.sv
// Self-checking bench for seq_divider_32bits: directed cases, control scenarios and
// randomized operands against a plain-arithmetic reference model.
module tb_seq_divider_32bits;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        op_done;
    logic        div_zero;

    int tests_run = 0;
    int tests_failed = 0;

    seq_divider_32bits dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_clear  (op_clear),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .op_done   (op_done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: truncating division in 64-bit arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // Present operands with op_start for one edge; returns at the sample after that edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        op_start  = 1'b1;
        @(negedge clk);
        op_start  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Counts busy samples until op_done; lat = -1 if the bound expires.
    task automatic wait_done(output int lat);
        int n;
        lat = 0;
        n   = 0;
        while (!op_done && n < 40) begin
            if (busy) lat++;
            @(negedge clk);
            n++;
        end
        if (!op_done) lat = -1;
    endtask

    task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s);
        logic [31:0] eq, er;
        logic        edz;
        int          lat, elat;
        model(a, b, s, eq, er, edz);
        elat = edz ? 0 : 32;
        issue(a, b, s);
        wait_done(lat);
        tests_run++;
        if (quotient !== eq || remainder !== er || div_zero !== edz || lat !== elat) begin
            tests_failed++;
            $display("FAIL %s a=%h b=%h s=%0d: got q=%h r=%h dz=%0d lat=%0d, want q=%h r=%h dz=%0d lat=%0d",
                     name, a, b, s, quotient, remainder, div_zero, lat, eq, er, edz, elat);
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b0 || op_done !== 1'b0 ||
            div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got q=%h r=%h busy=%0d done=%0d dz=%0d, want all zero",
                     quotient, remainder, busy, op_done, div_zero);
        end
    endtask

    task automatic test_directed;
        run_check("u100_7",     32'd100,       32'd7,         1'b0);
        run_check("s-100_7",    -32'sd100,     32'd7,         1'b1);
        tests_run++;
        if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL s-100_7_const: got q=%h r=%h, want q=fffffff2 r=fffffffe",
                     quotient, remainder);
        end
        run_check("s100_-7",    32'd100,       -32'sd7,       1'b1);
        run_check("uffff_1",    32'hFFFF_FFFF, 32'd1,         1'b0);
        run_check("smin_-1",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            tests_failed++;
            $display("FAIL smin_-1_const: got q=%h r=%h, want q=80000000 r=0", quotient, remainder);
        end
        run_check("u5_9",       32'd5,         32'd9,         1'b0);
        run_check("s-7_-2",     -32'sd7,       -32'sd2,       1'b1);
        run_check("uffff_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_check("u8000_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_div_zero;
        run_check("dz1234", 32'd1234, 32'd0, 1'b0);
        tests_run++;
        if (op_done !== 1'b1 || div_zero !== 1'b1 || quotient !== 32'hFFFF_FFFF ||
            remainder !== 32'd1234) begin
            tests_failed++;
            $display("FAIL dz_const: got done=%0d dz=%0d q=%h r=%h, want 1 1 ffffffff 000004d2",
                     op_done, div_zero, quotient, remainder);
        end
        run_check("dz_after", 32'd77, 32'd5, 1'b0);
    endtask

    task automatic test_start_ignored;
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        model(32'd1000, 32'd33, 1'b0, eq, er, edz);
        issue(32'd1000, 32'd33, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd0;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        lat = 6;
        wait_done(lat);
        tests_run++;
        if (lat !== 26 || quotient !== eq || remainder !== er || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ignored: got lat=%0d q=%h r=%h dz=%0d, want lat=26 q=%h r=%h dz=0",
                     lat, quotient, remainder, div_zero, eq, er);
        end
    endtask

    task automatic test_clear;
        int lat;
        run_check("pre_clear", 32'd500, 32'd3, 1'b0);
        issue(32'd123456, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || op_done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 ||
            div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_exec: got busy=%0d done=%0d q=%h r=%h dz=%0d, want all zero",
                     busy, op_done, quotient, remainder, div_zero);
        end
        // Clear and start together from DONE: clear wins.
        run_check("pre_clear2", 32'd99, 32'd4, 1'b0);
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd3;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || op_done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            tests_failed++;
            $display("FAIL clear_start: got busy=%0d done=%0d q=%h r=%h, want all zero",
                     busy, op_done, quotient, remainder);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== -1) begin
            tests_failed++;
            $display("FAIL clear_start_idle: got lat=%0d, want -1 (no operation started)", lat);
        end
    endtask

    task automatic test_async_reset;
        run_check("pre_reset", 32'd100, 32'd7, 1'b0);
        issue(32'd4000, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b0 || op_done !== 1'b0 ||
            div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got q=%h r=%h busy=%0d done=%0d dz=%0d, want all zero",
                     quotient, remainder, busy, op_done, div_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_check("post_reset", 32'd81, 32'd9, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd7;
        signed_op = 1'b0;
        op_start  = 1'b1;
        @(negedge clk);
        wait_done(lat);
        model(32'd1000, 32'd7, 1'b0, eq, er, edz);
        tests_run++;
        if (lat !== 32 || quotient !== eq || remainder !== er) begin
            tests_failed++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=32 q=%h r=%h",
                     lat, quotient, remainder, eq, er);
        end
        dividend  = -32'sd1000;
        divisor   = 32'd7;
        signed_op = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        wait_done(lat);
        model(-32'sd1000, 32'd7, 1'b1, eq, er, edz);
        tests_run++;
        if (lat !== 32 || quotient !== eq || remainder !== er) begin
            tests_failed++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=32 q=%h r=%h",
                     lat, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = -a;
            if ($urandom_range(0, 3) == 0) b = -b;
            if ($urandom_range(0, 99) == 0) b = 32'd0;
            s = 1'($urandom_range(0, 1));
            run_check("random", a, b, s);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        op_start  = 1'b0;
        op_clear  = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_zero();
        test_start_ignored();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
